single_port_ram: RTL and testbench

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

---
 rtl/single_port_ram_pkg.sv | 12 +
 rtl/single_port_ram_if.sv | 24 ++
 rtl/single_port_ram_array.sv | 37 +++
 rtl/single_port_ram.sv | 52 +++++
 tb/tb_single_port_ram.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/single_port_ram_pkg.sv
// Shared defaults and Wr_Rd encoding for the single-port RAM slice.
package single_port_ram_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } wr_rd_e;

endpackage

// File: rtl/single_port_ram_if.sv
// Request/response bus between a requester and single_port_ram.
interface single_port_ram_if #(
    parameter int unsigned DATA_W = single_port_ram_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = single_port_ram_pkg::ADDR_W_DEF
);

    logic              Wr_Rd;
    logic              valid;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              ready;

    modport master (
        output Wr_Rd, valid, ADDR, WDATA,
        input  RDATA, ready
    );

    modport slave (
        input  Wr_Rd, valid, ADDR, WDATA,
        output RDATA, ready
    );

endinterface

// File: rtl/single_port_ram_array.sv
// Storage array: synchronous clear and write, asynchronous read on one shared address.
module spram_array
    import single_port_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM top: ready handshake and read-data gating around spram_array.
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    single_port_ram_if.slave   bus
);

    logic              ready_q;
    logic              ready_d;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] arr_rdata;

    assign ready_d = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    always_comb begin
        wr_en = bus.valid && ready_q && (bus.Wr_Rd == WRITE);
        rd_en = bus.valid && ready_q && (bus.Wr_Rd == READ);
    end

    spram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .addr  (bus.ADDR),
        .wdata (bus.WDATA),
        .rdata (arr_rdata)
    );

    // Read data is forced to zero outside an active read so idle/write cycles never leak contents.
    assign bus.RDATA = rd_en ? arr_rdata : '0;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed plus randomized bench for single_port_ram against an array-based reference model.
module tb_single_port_ram;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;

    single_port_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    single_port_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              exp_ready;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rdata();
        if (bus.valid === 1'b1 && exp_ready && bus.Wr_Rd === 1'b0)
            return ref_mem[bus.ADDR];
        return '0;
    endfunction

    // Advance one clock edge, applying the edge's effect to the model first.
    task automatic tick();
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            exp_ready = 1'b0;
        end else begin
            if (bus.valid && exp_ready && bus.Wr_Rd) ref_mem[bus.ADDR] = bus.WDATA;
            exp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        check({tag, "_ready"}, {{(DATA_W-1){1'b0}}, bus.ready}, {{(DATA_W-1){1'b0}}, exp_ready});
        check({tag, "_rdata"}, bus.RDATA, exp_rdata());
    endtask

    task automatic read_all(input string tag);
        bus.valid = 1'b1;
        bus.Wr_Rd = 1'b0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            bus.ADDR = a[ADDR_W-1:0];
            #1;
            check(tag, bus.RDATA, ref_mem[a]);
        end
    endtask

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_ready = 1'b0;

        // Reset with a live write request that must be ignored.
        rst = 1'b1;
        bus.valid = 1'b1;
        bus.Wr_Rd = 1'b1;
        bus.ADDR  = 4'd2;
        bus.WDATA = 8'h77;
        tick();
        bus.Wr_Rd = 1'b0;
        tick();
        check_outputs("reset");
        check("reset_rdata_zero", bus.RDATA, 8'h00);

        rst = 1'b0;
        tick();
        check("ready_after_reset", {7'd0, bus.ready}, 8'h01);
        read_all("post_reset_zero");

        // Fill.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.valid = 1'b1;
            bus.Wr_Rd = 1'b1;
            bus.ADDR  = i[ADDR_W-1:0];
            bus.WDATA = 8'hA0 + i[7:0];
            check_outputs("fill_wr");
            tick();
        end
        read_all("fill_read");
        bus.ADDR = 4'd15;
        #1;
        check("fill_last_literal", bus.RDATA, 8'hAF);

        // Combinational read, one address per cycle.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.Wr_Rd = 1'b0;
            bus.ADDR  = i[ADDR_W-1:0];
            #1;
            check("comb_read", bus.RDATA, 8'hA0 + i[7:0]);
            tick();
        end

        // Gating.
        bus.valid = 1'b0;
        bus.Wr_Rd = 1'b1;
        bus.ADDR  = 4'd3;
        bus.WDATA = 8'h5C;
        check_outputs("gate_wr_invalid");
        tick();
        bus.Wr_Rd = 1'b0;
        check_outputs("gate_rd_invalid");
        bus.valid = 1'b1;
        check_outputs("gate_read3");
        check("gate_read3_literal", bus.RDATA, 8'hA3);
        bus.Wr_Rd = 1'b1;
        check_outputs("gate_wr_valid_rdata");

        // Overwrite and turnaround.
        bus.ADDR  = 4'd7;
        bus.WDATA = 8'h11;
        tick();
        bus.WDATA = 8'hEE;
        tick();
        bus.Wr_Rd = 1'b0;
        check_outputs("turnaround");
        check("turnaround_literal", bus.RDATA, 8'hEE);
        read_all("overwrite_others");

        // Randomized traffic, including intra-cycle address changes and rare resets.
        for (int unsigned n = 0; n < 300; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            bus.valid = $urandom_range(0, 3) != 0;
            bus.Wr_Rd = $urandom_range(0, 1) == 1;
            bus.ADDR  = ADDR_W'($urandom);
            bus.WDATA = DATA_W'($urandom);
            check_outputs("rand_a");
            bus.ADDR  = ADDR_W'($urandom);
            check_outputs("rand_b");
            tick();
        end
        rst = 1'b0;
        tick();
        read_all("rand_final");

        // Mid-run reset after a fresh fill.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.valid = 1'b1;
            bus.Wr_Rd = 1'b1;
            bus.ADDR  = i[ADDR_W-1:0];
            bus.WDATA = 8'hA0 + i[7:0];
            tick();
        end
        rst       = 1'b1;
        bus.ADDR  = 4'd5;
        bus.WDATA = 8'hFF;
        tick();
        rst = 1'b0;
        bus.Wr_Rd = 1'b0;
        check_outputs("midrst_cycle");
        check("midrst_ready_low", {7'd0, bus.ready}, 8'h00);
        tick();
        check("midrst_ready_high", {7'd0, bus.ready}, 8'h01);
        read_all("midrst_zero");
        bus.ADDR = 4'd5;
        #1;
        check("midrst_addr5_literal", bus.RDATA, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
